// File: rtl/wishbone_peripheral_bus_master_pkg.sv
// Shared definitions for the Wishbone-to-peripheral-bus initiator.
// Used by the top, which honours the optional PERIPHERAL_BUS_ERROR_EN build macro.
package wishbone_peripheral_bus_master_pkg;

    localparam int unsigned WINDOW_BITS  = 12;
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
    } state_e;

endpackage

// File: rtl/peripheral_bus_timeout_counter.sv
// Counts read-wait cycles on the peripheral bus; expired flags the last permitted cycle.
module peripheral_bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic increment,
    output logic expired
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (increment) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wishbone_peripheral_bus_master.sv
// Wishbone classic slave that turns each single access into one 12-bit peripheral bus access.
// Define PERIPHERAL_BUS_ERROR_EN to report timed-out reads on wb_err_o instead of wb_ack_o.
module wishbone_peripheral_bus_master
    import wishbone_peripheral_bus_master_pkg::*;
#(
    parameter logic [11:0] BASE_ADDRESS   = 12'h000,
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [23:0]            wb_adr_i,
    input  logic [31:0]            wb_data_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [31:0]            wb_data_o,
    output logic                   peripheralBus_enable,
    output logic                   peripheralBus_we,
    output logic                   peripheralBus_oe,
    output logic [WINDOW_BITS-1:0] peripheralBus_address,
    output logic [3:0]             peripheralBus_byteSelect,
    output logic [31:0]            peripheralBus_dataWrite,
    input  logic [31:0]            peripheralBus_dataRead,
    input  logic                   peripheralBus_requestOutput
);

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d, err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   enable_q, enable_d, we_q, we_d, oe_q, oe_d;
    logic                   we_lat_q, we_lat_d;
    logic [WINDOW_BITS-1:0] address_q, address_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   cnt_clear, cnt_inc, cnt_expired;

    peripheral_bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .increment(cnt_inc),
        .expired  (cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            enable_q  <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            we_lat_q  <= 1'b0;
            address_q <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            enable_q  <= enable_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            we_lat_q  <= we_lat_d;
            address_q <= address_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
        end
    end

    // Bus output registers are zero unless the next state is ACCESS.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        enable_d  = 1'b0;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        we_lat_d  = we_lat_q;
        address_d = '0;
        sel_d     = '0;
        wdata_d   = '0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                if (wb_cyc_i && wb_stb_i && wb_adr_i[23:12] == BASE_ADDRESS) begin
                    state_d   = StAccess;
                    we_lat_d  = wb_we_i;
                    enable_d  = 1'b1;
                    we_d      = wb_we_i;
                    oe_d      = !wb_we_i;
                    address_d = wb_adr_i[WINDOW_BITS-1:0];
                    sel_d     = wb_sel_i;
                    wdata_d   = wb_data_i;
                end
            end
            StAccess: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (we_lat_q) begin
                    state_d = StRespond;
                    ack_d   = 1'b1;
                end else if (peripheralBus_requestOutput) begin
                    state_d = StRespond;
                    ack_d   = 1'b1;
                    rdata_d = peripheralBus_dataRead;
                end else if (cnt_expired) begin
                    state_d = StRespond;
                    rdata_d = TIMEOUT_DATA;
`ifdef PERIPHERAL_BUS_ERROR_EN
                    err_d   = 1'b1;
`else
                    ack_d   = 1'b1;
`endif
                end else begin
                    cnt_inc   = 1'b1;
                    enable_d  = 1'b1;
                    oe_d      = 1'b1;
                    address_d = address_q;
                    sel_d     = sel_q;
                    wdata_d   = wdata_q;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wb_ack_o                 = ack_q;
    assign wb_err_o                 = err_q;
    assign wb_data_o                = rdata_q;
    assign peripheralBus_enable     = enable_q;
    assign peripheralBus_we         = we_q;
    assign peripheralBus_oe         = oe_q;
    assign peripheralBus_address    = address_q;
    assign peripheralBus_byteSelect = sel_q;
    assign peripheralBus_dataWrite  = wdata_q;

endmodule

// File: tb/tb_wishbone_peripheral_bus_master.sv
// Directed bench for wishbone_peripheral_bus_master (BASE 12'h000, TIMEOUT_CYCLES 4).
module tb_wishbone_peripheral_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [23:0] adr;
    logic [31:0] wdat;
    logic        ack, err;
    logic [31:0] dout;
    logic        en, pwe, poe;
    logic [11:0] paddr;
    logic [3:0]  psel;
    logic [31:0] pwdata;
    logic [31:0] rdat;
    logic        req;

    int passed = 0;
    int total  = 0;

`ifdef PERIPHERAL_BUS_ERROR_EN
    localparam logic EXP_TO_ACK = 1'b0;
    localparam logic EXP_TO_ERR = 1'b1;
`else
    localparam logic EXP_TO_ACK = 1'b1;
    localparam logic EXP_TO_ERR = 1'b0;
`endif

    wishbone_peripheral_bus_master #(
        .BASE_ADDRESS  (12'h000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .wb_cyc_i                   (cyc),
        .wb_stb_i                   (stb),
        .wb_we_i                    (we),
        .wb_sel_i                   (sel),
        .wb_adr_i                   (adr),
        .wb_data_i                  (wdat),
        .wb_ack_o                   (ack),
        .wb_err_o                   (err),
        .wb_data_o                  (dout),
        .peripheralBus_enable       (en),
        .peripheralBus_we           (pwe),
        .peripheralBus_oe           (poe),
        .peripheralBus_address      (paddr),
        .peripheralBus_byteSelect   (psel),
        .peripheralBus_dataWrite    (pwdata),
        .peripheralBus_dataRead     (rdat),
        .peripheralBus_requestOutput(req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0; req = 0; rdat = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 24'h000010; wdat = 32'h1234_5678;
        rst = 1;
        tick(); tick();
        total++; if ({ack, err, en, pwe, poe} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {ack, err, en, pwe, poe}); else passed++;
        total++; if (paddr !== 12'h0) $display("FAIL reset_addr got %h want 000", paddr); else passed++;
        total++; if ({psel, pwdata} !== 36'h0) $display("FAIL reset_bus_data got %h want 0", {psel, pwdata}); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL reset_wb_data got %h want 00000000", dout); else passed++;
        idle_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_write();
        cyc = 1; stb = 1; we = 1; adr = 24'h000010; sel = 4'b0011; wdat = 32'hDEAD_BEEF;
        tick();
        total++; if ({en, pwe, poe, ack} !== 4'b1100) $display("FAIL write_c1_ctrl got %b want 1100", {en, pwe, poe, ack}); else passed++;
        total++; if (paddr !== 12'h010) $display("FAIL write_c1_addr got %h want 010", paddr); else passed++;
        total++; if (psel !== 4'b0011) $display("FAIL write_c1_sel got %b want 0011", psel); else passed++;
        total++; if (pwdata !== 32'hDEAD_BEEF) $display("FAIL write_c1_data got %h want deadbeef", pwdata); else passed++;
        tick();
        total++; if ({ack, err, en, poe} !== 4'b1000) $display("FAIL write_c2_ack got %b want 1000", {ack, err, en, poe}); else passed++;
        idle_inputs();
        tick();
        total++; if (ack !== 1'b0) $display("FAIL write_ack_pulse got %b want 0", ack); else passed++;
    endtask

    task automatic test_read_answered();
        cyc = 1; stb = 1; we = 0; adr = 24'h000010; sel = 4'hF;
        tick();
        total++; if ({en, pwe, poe, ack} !== 4'b1010) $display("FAIL read_c1_ctrl got %b want 1010", {en, pwe, poe, ack}); else passed++;
        req = 1; rdat = 32'h0000_BEEF;
        tick();
        total++; if ({ack, err, poe} !== 3'b100) $display("FAIL read_c2_ack got %b want 100", {ack, err, poe}); else passed++;
        total++; if (dout !== 32'h0000_BEEF) $display("FAIL read_data got %h want 0000beef", dout); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        cyc = 1; stb = 1; we = 0; adr = 24'h000040; sel = 4'hF;
        tick();
        req = 1; rdat = 32'hCAFE_0001;
        tick();
        total++; if (ack !== 1'b1) $display("FAIL b2b_read_ack got %b want 1", ack); else passed++;
        // Strobe held straight into a write: must not start until after RESPOND.
        req = 0; rdat = '0; we = 1; adr = 24'h000020; wdat = 32'h55AA_55AA;
        tick();
        total++; if ({en, ack} !== 2'b00) $display("FAIL b2b_c3_idle got %b want 00", {en, ack}); else passed++;
        tick();
        total++; if ({en, pwe, paddr} !== {2'b11, 12'h020}) $display("FAIL b2b_c4_access got %h want 3020", {en, pwe, paddr}); else passed++;
        tick();
        total++; if (ack !== 1'b1) $display("FAIL b2b_write_ack got %b want 1", ack); else passed++;
        total++; if (dout !== 32'hCAFE_0001) $display("FAIL b2b_data_hold got %h want cafe0001", dout); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int oe_cycles = 0;
        int resp_cycle = 0;
        logic got_ack = 0;
        logic got_err = 0;
        logic [31:0] got_data = '0;
        cyc = 1; stb = 1; we = 0; adr = 24'h000FFC; sel = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (poe) oe_cycles++;
            if ((ack || err) && resp_cycle == 0) begin
                resp_cycle = c; got_ack = ack; got_err = err; got_data = dout;
                cyc = 0; stb = 0;
            end
        end
        total++; if (oe_cycles !== 4) $display("FAIL timeout_oe_cycles got %0d want 4", oe_cycles); else passed++;
        total++; if (resp_cycle !== 5) $display("FAIL timeout_resp_cycle got %0d want 5", resp_cycle); else passed++;
        total++; if ({got_ack, got_err} !== {EXP_TO_ACK, EXP_TO_ERR}) $display("FAIL timeout_ack_err got %b want %b", {got_ack, got_err}, {EXP_TO_ACK, EXP_TO_ERR}); else passed++;
        total++; if (got_data !== 32'hFFFF_FFFF) $display("FAIL timeout_data got %h want ffffffff", got_data); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_unmapped();
        int activity = 0;
        cyc = 1; stb = 1; we = 1; adr = 24'h001010; sel = 4'hF; wdat = 32'h0F0F_0F0F;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (en || pwe || poe || ack || err) activity++;
        end
        total++; if (activity !== 0) $display("FAIL unmapped_activity got %0d want 0", activity); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_cyc_drop();
        cyc = 1; stb = 1; we = 0; adr = 24'h000010; sel = 4'hF;
        tick();
        total++; if ({en, poe} !== 2'b11) $display("FAIL drop_c1_ctrl got %b want 11", {en, poe}); else passed++;
        tick();
        total++; if ({en, poe, ack} !== 3'b110) $display("FAIL drop_c2_wait got %b want 110", {en, poe, ack}); else passed++;
        cyc = 0; stb = 0;
        tick();
        total++; if ({en, pwe, poe, ack, err} !== 5'b0) $display("FAIL drop_c3_ctrl got %b want 00000", {en, pwe, poe, ack, err}); else passed++;
        total++; if (paddr !== 12'h0) $display("FAIL drop_c3_addr got %h want 000", paddr); else passed++;
        tick();
        total++; if ({ack, err} !== 2'b00) $display("FAIL drop_c4_noresp got %b want 00", {ack, err}); else passed++;
        total++; if (dout !== 32'hFFFF_FFFF) $display("FAIL drop_data_hold got %h want ffffffff", dout); else passed++;
    endtask

    task automatic test_reset_mid_access();
        cyc = 1; stb = 1; we = 0; adr = 24'h000010; sel = 4'hF;
        tick();
        total++; if (poe !== 1'b1) $display("FAIL rstmid_c1_oe got %b want 1", poe); else passed++;
        rst = 1;
        tick();
        total++; if ({ack, err, en, pwe, poe, paddr, psel, pwdata, dout} !== 'b0) $display("FAIL rstmid_outputs got nonzero en=%b oe=%b addr=%h dout=%h", en, poe, paddr, dout); else passed++;
        rst = 0;
        idle_inputs();
        tick();
        total++; if ({ack, err, en} !== 3'b000) $display("FAIL rstmid_noresp got %b want 000", {ack, err, en}); else passed++;
        cyc = 1; stb = 1; we = 1; adr = 24'h000004; sel = 4'hF; wdat = 32'h0BAD_F00D;
        tick();
        total++; if ({en, pwe, pwdata} !== {2'b11, 32'h0BAD_F00D}) $display("FAIL rstmid_write_c1 got %h want 30badf00d", {en, pwe, pwdata}); else passed++;
        tick();
        total++; if (ack !== 1'b1) $display("FAIL rstmid_write_ack got %b want 1", ack); else passed++;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_read_answered();
        test_back_to_back();
        test_timeout();
        test_unmapped();
        test_cyc_drop();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
